// File: rtl/bs_stream_pkg.sv
// Shared types and byte constants for the Annex-B byte streamer.
package bs_stream_pkg;

    typedef enum logic [2:0] {
        SCAN_HEAD0,
        SCAN_HEAD1,
        SCAN_HEAD2,
        SCAN_IN_FRAME,
        SCAN_JUDGE0,
        SCAN_JUDGE1
    } scan_state_e;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_RUN,
        TOP_DONE
    } top_state_e;

    localparam logic [7:0] SC_ZERO = 8'h00;
    localparam logic [7:0] SC_ONE  = 8'h01;
    localparam logic [7:0] SC_EPB  = 8'h03;

endpackage

// File: rtl/bs_start_code_scan.sv
// Start-code / emulation-prevention scanner; judges the byte at the head of the
// buffer combinationally and advances only when that byte is consumed.
module bs_start_code_scan
    import bs_stream_pkg::*;
#(
    parameter bit STRIP_EPB = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] cur_byte,
    input  logic       consume,
    output logic       nal_start,
    output logic       frame_close,
    output logic       drop,
    output logic       frame_started
);

    scan_state_e state_q, state_d;
    logic        started_q;

    assign frame_started = started_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCAN_HEAD0;
            started_q <= 1'b0;
        end else if (clear) begin
            state_q   <= SCAN_HEAD0;
            started_q <= 1'b0;
        end else if (consume) begin
            state_q <= state_d;
            if (state_q == SCAN_HEAD2 && cur_byte == SC_ONE) begin
                started_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        nal_start   = 1'b0;
        frame_close = 1'b0;
        drop        = 1'b0;
        case (state_q)
            SCAN_HEAD0: begin
                if (cur_byte == SC_ZERO) state_d = SCAN_HEAD1;
            end
            SCAN_HEAD1: begin
                state_d = (cur_byte == SC_ZERO) ? SCAN_HEAD2 : SCAN_HEAD0;
            end
            SCAN_HEAD2: begin
                if (cur_byte == SC_ONE) begin
                    state_d   = SCAN_IN_FRAME;
                    nal_start = 1'b1;
                end else if (cur_byte != SC_ZERO) begin
                    state_d = SCAN_HEAD0;
                end
            end
            SCAN_IN_FRAME: begin
                if (cur_byte == SC_ZERO) state_d = SCAN_JUDGE0;
            end
            SCAN_JUDGE0: begin
                state_d = (cur_byte == SC_ZERO) ? SCAN_JUDGE1 : SCAN_IN_FRAME;
            end
            SCAN_JUDGE1: begin
                // A zero run of any length keeps us here until the deciding byte.
                if (cur_byte == SC_ZERO) begin
                    state_d = SCAN_JUDGE1;
                end else begin
                    state_d = SCAN_IN_FRAME;
                    if (cur_byte == SC_ONE) begin
                        nal_start   = 1'b1;
                        frame_close = 1'b1;
                    end else if (STRIP_EPB && cur_byte == SC_EPB) begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_d = SCAN_HEAD0;
        endcase
    end

endmodule

// File: rtl/bs_byte_streamer.sv
// Serialises wide Annex-B beats into a byte stream, counting frames and
// optionally stripping emulation-prevention bytes; stops after FRAME_LIMIT frames.
module bs_byte_streamer
    import bs_stream_pkg::*;
#(
    parameter int IN_BYTES    = 16,
    parameter int FRAME_LIMIT = 1,
    parameter bit STRIP_EPB   = 1'b0,
    parameter int CNT_W       = 16,
    localparam int NB_W       = $clog2(IN_BYTES + 1),
    localparam int DW         = 8 * IN_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    in_data,
    input  logic [NB_W-1:0]  in_nbytes,
    input  logic             in_last,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [7:0]       out_byte,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             nal_start,
    output logic             frame_started,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] epb_cnt,
    output logic             done,
    output logic             eos_early
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(FRAME_LIMIT - 1);

    top_state_e      state_q, state_d;
    logic [DW-1:0]   buf_q;
    logic [NB_W-1:0] cnt_q;
    logic            last_q;

    logic run, has_byte, byte_hs, consume, load, arm;
    logic limit_hit, stream_end, term;
    logic scan_nal, scan_close, scan_drop, scan_started;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits for ready and, once raised, holds with its
    // data until accepted.
    assign run      = (state_q == TOP_RUN);
    assign has_byte = run & (cnt_q != '0);
    assign out_byte = buf_q[DW-1 -: 8];
    assign out_vld  = has_byte & ~scan_drop;
    assign byte_hs  = out_vld & out_rdy;
    assign consume  = has_byte & (scan_drop | out_rdy);

    assign limit_hit  = (FRAME_LIMIT != 0) & byte_hs & scan_close & (frame_cnt == LIMIT_M1);
    assign stream_end = consume & last_q & (cnt_q == NB_W'(1));
    assign term       = limit_hit | stream_end;

    // The buffer refills only once drained, so in_rdy never looks at in_vld.
    assign in_rdy = run & ~term & ((cnt_q == '0) | ((cnt_q == NB_W'(1)) & byte_hs));
    assign load   = in_vld & in_rdy;
    assign arm    = start & (state_q != TOP_RUN);

    assign nal_start     = byte_hs & scan_nal;
    assign frame_started = run & scan_started;

    bs_start_code_scan #(
        .STRIP_EPB(STRIP_EPB)
    ) u_scan (
        .clk          (clk),
        .rst          (rst),
        .clear        (arm),
        .cur_byte     (out_byte),
        .consume      (consume),
        .nal_start    (scan_nal),
        .frame_close  (scan_close),
        .drop         (scan_drop),
        .frame_started(scan_started)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TOP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TOP_IDLE: if (start) state_d = TOP_RUN;
            TOP_RUN:  if (term)  state_d = TOP_DONE;
            TOP_DONE: if (start) state_d = TOP_RUN;
            default:  state_d = TOP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            frame_cnt <= '0;
            epb_cnt   <= '0;
            done      <= 1'b0;
            eos_early <= 1'b0;
        end else if (arm) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            frame_cnt <= '0;
            epb_cnt   <= '0;
            done      <= 1'b0;
            eos_early <= 1'b0;
        end else begin
            if (load) begin
                buf_q  <= in_data;
                cnt_q  <= in_nbytes;
                last_q <= in_last;
            end else if (term) begin
                // Whatever is left of the beat after the terminating byte is discarded.
                cnt_q <= '0;
            end else if (consume) begin
                buf_q <= buf_q << 8;
                cnt_q <= cnt_q - 1'b1;
            end
            if (byte_hs && scan_close && frame_cnt != '1) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (consume && scan_drop && epb_cnt != '1) begin
                epb_cnt <= epb_cnt + 1'b1;
            end
            if (term) begin
                done      <= 1'b1;
                eos_early <= stream_end & ~limit_hit & (FRAME_LIMIT != 0);
            end
        end
    end

endmodule

// File: tb/tb_bs_byte_streamer.sv
// Directed and randomized bench for bs_byte_streamer over three parameter sets,
// checked against a pattern-matching model of the byte stream.
module tb_bs_byte_streamer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a   [NI];
    logic [31:0] in_data_a [NI];
    logic [2:0]  in_nb_a   [NI];
    logic        in_last_a [NI];
    logic        in_vld_a  [NI];
    logic        in_rdy_a  [NI];
    logic [7:0]  out_byte_a[NI];
    logic        out_vld_a [NI];
    logic        out_rdy_a [NI];
    logic        nal_a     [NI];
    logic        fs_a      [NI];
    logic [15:0] fcnt_a    [NI];
    logic [15:0] ecnt_a    [NI];
    logic        done_a    [NI];
    logic        eos_a     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int FL = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
        localparam bit SE = (g == 0) ? 1'b0 : 1'b1;
        bs_byte_streamer #(
            .IN_BYTES(4), .FRAME_LIMIT(FL), .STRIP_EPB(SE), .CNT_W(16)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start_a[g]),
            .in_data(in_data_a[g]), .in_nbytes(in_nb_a[g]), .in_last(in_last_a[g]),
            .in_vld(in_vld_a[g]), .in_rdy(in_rdy_a[g]),
            .out_byte(out_byte_a[g]), .out_vld(out_vld_a[g]), .out_rdy(out_rdy_a[g]),
            .nal_start(nal_a[g]), .frame_started(fs_a[g]),
            .frame_cnt(fcnt_a[g]), .epb_cnt(ecnt_a[g]),
            .done(done_a[g]), .eos_early(eos_a[g])
        );
    end

    function automatic int cfg_fl(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 2 : 0);
    endfunction

    function automatic bit cfg_strip(input int idx);
        return (idx != 0);
    endfunction

    int tests = 0;
    int fails = 0;

    logic [31:0] bt_data[$];
    int          bt_nb[$];
    bit          bt_last[$];

    logic [7:0] exp_q[$];
    int         exp_frames, exp_epb, exp_nal;
    bit         exp_eos;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic clear_beats();
        bt_data.delete();
        bt_nb.delete();
        bt_last.delete();
    endtask

    task automatic add_beat(input logic [31:0] d, input int nb, input bit last);
        bt_data.push_back(d);
        bt_nb.push_back(nb);
        bt_last.push_back(last);
    endtask

    // Start codes and EPBs are found by looking at the two raw bytes before each
    // position; only zeros after the first start code count inside frames.
    task automatic build_model(input int fl, input bit strip);
        logic [7:0]  raw[$];
        logic [31:0] d;
        int          last_idx, first;
        bit          sc, ep, zin;
        raw.delete();
        last_idx = -1;
        for (int b = 0; b < bt_data.size(); b++) begin
            for (int j = 0; j < bt_nb[b]; j++) begin
                d = bt_data[b] << (8 * j);
                raw.push_back(d[31:24]);
            end
            if (bt_last[b]) begin
                last_idx = raw.size() - 1;
                break;
            end
        end
        exp_q.delete();
        exp_frames = 0; exp_epb = 0; exp_nal = 0; exp_eos = 1'b0;
        first = -1;
        for (int k = 0; k < raw.size(); k++) begin
            sc = 1'b0; ep = 1'b0;
            if (k >= 2) begin
                if (raw[k-1] == 8'h00 && raw[k-2] == 8'h00) begin
                    sc = (raw[k] == 8'h01);
                    ep = (raw[k] == 8'h03);
                end
            end
            zin = (first >= 0) && (k - 2 > first);
            if (first < 0) begin
                exp_q.push_back(raw[k]);
                if (sc) begin
                    first = k;
                    exp_nal++;
                end
            end else begin
                if (strip && ep && zin) exp_epb++;
                else exp_q.push_back(raw[k]);
                if (sc && zin) begin
                    exp_frames++;
                    exp_nal++;
                    if (fl != 0 && exp_frames == fl) break;
                end
            end
            if (k == last_idx) begin
                exp_eos = (fl != 0);
                break;
            end
        end
    endtask

    task automatic present(input int idx, input int bi);
        if (bi < bt_data.size()) begin
            in_vld_a[idx]  = 1'b1;
            in_data_a[idx] = bt_data[bi];
            in_nb_a[idx]   = 3'(bt_nb[bi]);
            in_last_a[idx] = bt_last[bi];
        end else begin
            in_vld_a[idx]  = 1'b0;
            in_data_a[idx] = '0;
            in_nb_a[idx]   = '0;
            in_last_a[idx] = 1'b0;
        end
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk({tag, "_out_vld"}, 32'(out_vld_a[idx]), 0);
        chk({tag, "_in_rdy"},  32'(in_rdy_a[idx]), 0);
        chk({tag, "_out_byte"}, 32'(out_byte_a[idx]), 0);
        chk({tag, "_nal"},     32'(nal_a[idx]), 0);
        chk({tag, "_fs"},      32'(fs_a[idx]), 0);
        chk({tag, "_fcnt"},    32'(fcnt_a[idx]), 0);
        chk({tag, "_ecnt"},    32'(ecnt_a[idx]), 0);
        chk({tag, "_done"},    32'(done_a[idx]), 0);
        chk({tag, "_eos"},     32'(eos_a[idx]), 0);
    endtask

    function automatic logic rdy_for(input int mode, input int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[3 - (cyc % 4)];
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_stream(input int idx, input int mode, input string tag);
        int   bi, nal_seen, done_cyc, last_hs_cyc;
        bit   prev_stall, taken, got_done;
        logic [7:0]  prev_byte;
        logic [31:0] expb;
        build_model(cfg_fl(idx), cfg_strip(idx));
        bi = 0; nal_seen = 0; done_cyc = -1; last_hs_cyc = -100;
        prev_stall = 1'b0; prev_byte = '0; got_done = 1'b0;
        @(posedge clk); #1;
        start_a[idx]   = 1'b1;
        out_rdy_a[idx] = rdy_for(mode, 0);
        present(idx, bi);
        @(posedge clk); #1;
        start_a[idx] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (done_a[idx]) begin
                done_cyc = cyc;
                got_done = 1'b1;
                break;
            end
            if (prev_stall) begin
                chk({tag, "_hold_vld"}, 32'(out_vld_a[idx]), 1);
                chk({tag, "_hold_byte"}, 32'(out_byte_a[idx]), 32'(prev_byte));
            end
            if (out_vld_a[idx] && !out_rdy_a[idx])
                chk({tag, "_stall_in_rdy"}, 32'(in_rdy_a[idx]), 0);
            chk({tag, "_frame_started"}, 32'(fs_a[idx]), (nal_seen > 0) ? 1 : 0);
            prev_stall = out_vld_a[idx] && !out_rdy_a[idx];
            prev_byte  = out_byte_a[idx];
            if (out_vld_a[idx] && out_rdy_a[idx]) begin
                expb = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
                chk({tag, "_byte"}, 32'(out_byte_a[idx]), expb);
                last_hs_cyc = cyc;
            end
            if (nal_a[idx]) nal_seen++;
            taken = in_vld_a[idx] && in_rdy_a[idx];
            @(posedge clk); #1;
            if (taken) begin
                bi++;
                present(idx, bi);
            end
            out_rdy_a[idx] = rdy_for(mode, cyc + 1);
        end
        chk({tag, "_done"}, 32'(got_done), 1);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_frame_cnt"}, 32'(fcnt_a[idx]), exp_frames);
        chk({tag, "_epb_cnt"}, 32'(ecnt_a[idx]), exp_epb);
        chk({tag, "_eos_early"}, 32'(eos_a[idx]), 32'(exp_eos));
        chk({tag, "_nal_count"}, nal_seen, exp_nal);
        chk({tag, "_post_in_rdy"}, 32'(in_rdy_a[idx]), 0);
        chk({tag, "_post_out_vld"}, 32'(out_vld_a[idx]), 0);
        if (got_done && cfg_fl(idx) != 0 && !exp_eos)
            chk({tag, "_done_latency"}, done_cyc - last_hs_cyc, 1);
        present(idx, bt_data.size());
        out_rdy_a[idx] = 1'b0;
    endtask

    task automatic load_scenario1();
        clear_beats();
        add_beat(32'hAA000000, 4, 1'b0);
        add_beat(32'h01401122, 4, 1'b0);
        add_beat(32'h00000001, 4, 1'b0);
        add_beat(32'h55667788, 4, 1'b1);
    endtask

    task automatic load_random(input int nbeats);
        logic [31:0] d;
        int          r;
        clear_beats();
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            for (int j = 0; j < 4; j++) begin
                r = $urandom_range(0, 9);
                d = d << 8;
                if (r <= 4)      d[7:0] = 8'h00;
                else if (r <= 6) d[7:0] = 8'h01;
                else if (r == 7) d[7:0] = 8'h03;
                else             d[7:0] = 8'($urandom_range(0, 255));
            end
            add_beat(d, $urandom_range(1, 4), b == nbeats - 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 1'b0;
            out_rdy_a[i] = 1'b0;
            in_vld_a[i] = 1'b0;
            in_data_a[i] = '0;
            in_nb_a[i] = '0;
            in_last_a[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk_idle(i, "reset");
        rst = 1'b0;

        load_scenario1();
        run_stream(0, 0, "s1_basic");

        clear_beats();
        add_beat(32'h00000001, 4, 1'b0);
        add_beat(32'h40000001, 4, 1'b0);
        add_beat(32'h42000001, 4, 1'b0);
        add_beat(32'h44000000, 4, 1'b1);
        run_stream(1, 0, "s2_limit2");

        clear_beats();
        add_beat(32'h00000001, 4, 1'b0);
        add_beat(32'h40000003, 4, 1'b0);
        add_beat(32'h02AA0000, 2, 1'b1);
        run_stream(1, 0, "s3_strip");
        run_stream(0, 0, "s3_nostrip");

        load_scenario1();
        run_stream(0, 1, "s4_stall");

        clear_beats();
        add_beat(32'h12340000, 2, 1'b1);
        run_stream(0, 0, "s5_eos");

        clear_beats();
        add_beat(32'h00000001, 4, 1'b0);
        add_beat(32'h11000001, 4, 1'b0);
        add_beat(32'h22330000, 3, 1'b1);
        run_stream(2, 0, "s6_unlimited");

        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 3; r++) begin
                load_random($urandom_range(4, 8));
                run_stream(i, 2, "rand");
            end
        end

        // Reset in the middle of a beat, then replay the first stream.
        @(posedge clk); #1;
        start_a[0] = 1'b1;
        out_rdy_a[0] = 1'b1;
        in_vld_a[0] = 1'b1;
        in_data_a[0] = 32'hAA000000;
        in_nb_a[0] = 3'd4;
        in_last_a[0] = 1'b0;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        @(posedge clk); #1;
        in_vld_a[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_pre_vld", 32'(out_vld_a[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk_idle(0, "mid_rst");
        out_rdy_a[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        load_scenario1();
        run_stream(0, 0, "s7_restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
